seg_msg_scan: RTL and testbench

SEG_MSG_SCAN -- requirements
Module: seg_msg_scan

---
 rtl/seg_msg_scan.sv | 168 ++++++++++++++++
 tb/tb_seg_msg_scan.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_msg_scan.sv
// Multiplexed 7-segment message screen: scans a glyph buffer across DIGITS digits
// with optional scroll and blink, and exits to DONE on a fresh keypress.
module seg_msg_scan #(
  parameter int DIGITS        = 8,
  parameter int DIV           = 25000,
  parameter int MSG_LEN       = 16,
  parameter int SCROLL_FRAMES = 64,
  parameter int BLINK_FRAMES  = 32,
  parameter int KEYS          = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [KEYS-1:0]            key_data,
  input  logic                       msg_we,
  input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
  input  logic [6:0]                 msg_data,
  output logic [6:0]                 seg_txt,
  output logic [DIGITS-1:0]          seg_com,
  output logic                       key_hit,
  output logic                       busy
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t          state, nxt_state;
  logic            key_sync_p0, key_sync_p1, key_prev_p2;
  logic            key_edge;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   offset, off_disp, rd_addr;
  logic [SW-1:0]   scroll_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_ph;
  logic [1:0]      mode_r;
  logic            upd_p0;
  logic [DIGITS-1:0] com_sel;
  logic [6:0]      glyph_mem [MSG_LEN];

  // Keypad synchronizer; the edge detector runs in every state so a key held
  // across SHOW entry never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_p0 <= 1'b0;
      key_sync_p1 <= 1'b0;
      key_prev_p2 <= 1'b0;
    end else begin
      key_sync_p0 <= |key_data;
      key_sync_p1 <= key_sync_p0;
      key_prev_p2 <= key_sync_p1;
    end
  end

  assign key_edge = key_sync_p1 & ~key_prev_p2 & (state == SHOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (enable) nxt_state = SHOW;
      SHOW:    if (!enable) nxt_state = IDLE;
               else if (key_edge) nxt_state = DONE;
      DONE:    if (!enable) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign busy = (state == SHOW);
  assign tick = (cnt == CW'(DIV - 1));

  // Scan counters; everything is held cleared outside SHOW so entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      offset     <= '0;
      scroll_cnt <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      mode_r     <= 2'b00;
    end else if (state != SHOW) begin
      cnt        <= '0;
      idx        <= '0;
      offset     <= '0;
      scroll_cnt <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      mode_r     <= mode;
    end else if (tick) begin
      cnt <= '0;
      if (idx == IW'(DIGITS - 1)) begin
        idx    <= '0;
        mode_r <= mode;
        if (scroll_cnt == SW'(SCROLL_FRAMES - 1)) begin
          scroll_cnt <= '0;
          if (mode_r[0]) offset <= offset + AW'(1);
        end else begin
          scroll_cnt <= scroll_cnt + SW'(1);
        end
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        idx <= idx + IW'(1);
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign off_disp = mode_r[0] ? offset : '0;
  assign rd_addr  = off_disp + AW'(idx);

  always_comb begin
    com_sel = '1;
    com_sel[IW'(DIGITS - 1) - idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) glyph_mem[i] <= 7'h7F;
    end else if (msg_we) begin
      glyph_mem[msg_addr] <= msg_data;
    end
  end

  // Segment outputs latch only once per slot, so a glyph rewrite mid-slot
  // shows on the next refresh of that digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_com <= '1;
      seg_txt <= 7'h7F;
      key_hit <= 1'b0;
      upd_p0  <= 1'b0;
    end else begin
      key_hit <= (state == SHOW) && (nxt_state == DONE);
      upd_p0  <= (state != SHOW) || tick;
      if (state != SHOW || nxt_state != SHOW) begin
        seg_com <= '1;
        seg_txt <= 7'h7F;
      end else if (upd_p0) begin
        if (mode_r[1] && blink_ph) begin
          seg_com <= '1;
          seg_txt <= 7'h7F;
        end else begin
          seg_com <= com_sel;
          seg_txt <= glyph_mem[rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_msg_scan.sv
// Directed bench for seg_msg_scan with DIGITS=8, DIV=4, MSG_LEN=16,
// SCROLL_FRAMES=2, BLINK_FRAMES=2 (one frame = 32 clk).
module tb_seg_msg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] key_data;
  logic        msg_we;
  logic [3:0]  msg_addr;
  logic [6:0]  msg_data;
  logic [6:0]  seg_txt;
  logic [7:0]  seg_com;
  logic        key_hit;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  seg_msg_scan #(
    .DIGITS(8), .DIV(4), .MSG_LEN(16), .SCROLL_FRAMES(2), .BLINK_FRAMES(2), .KEYS(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .key_data(key_data),
    .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
    .seg_txt(seg_txt), .seg_com(seg_com), .key_hit(key_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_com(input int i);
    logic [7:0] msb;
    msb = 8'h80;
    return 8'hFF ^ (msb >> i);
  endfunction

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; key_data = '0;
    msg_we = 1'b0; msg_addr = '0; msg_data = '0;
    step(2);
    chk("rst_com", 32'(seg_com), 32'hFF);
    chk("rst_txt", 32'(seg_txt), 32'h7F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hit", 32'(key_hit), 32'h0);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 8; i++) begin
      msg_we = 1'b1; msg_addr = 4'(i); msg_data = 7'(i);
      step(1);
    end
    msg_we = 1'b0;

    // static scan
    mode = 2'b00; enable = 1'b1;
    step(1);
    chk("entry_busy", 32'(busy), 32'h1);
    chk("entry_com_blank", 32'(seg_com), 32'hFF);
    step(1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("static_com%0d", i), 32'(seg_com), 32'(exp_com(i)));
      chk($sformatf("static_txt%0d", i), 32'(seg_txt), i);
      step(4);
    end
    chk("static_wrap_com", 32'(seg_com), 32'h7F);
    chk("static_wrap_txt", 32'(seg_txt), 32'h0);

    // scroll
    enable = 1'b0; step(2);
    mode = 2'b01; enable = 1'b1; step(2);
    chk("scroll_f0_txt", 32'(seg_txt), 32'h0);
    step(64);
    chk("scroll_f2_com", 32'(seg_com), 32'h7F);
    chk("scroll_f2_txt", 32'(seg_txt), 32'h1);
    step(924);
    chk("scroll_off15_com", 32'(seg_com), 32'hFE);
    chk("scroll_off15_txt", 32'(seg_txt), 32'h6);
    step(36);
    chk("scroll_wrap_com", 32'(seg_com), 32'h7F);
    chk("scroll_wrap_txt", 32'(seg_txt), 32'h0);

    // blink
    enable = 1'b0; step(2);
    mode = 2'b10; enable = 1'b1; step(2);
    chk("blink_f0_com", 32'(seg_com), 32'h7F);
    chk("blink_f0_txt", 32'(seg_txt), 32'h0);
    step(64);
    chk("blink_f2_com", 32'(seg_com), 32'hFF);
    chk("blink_f2_txt", 32'(seg_txt), 32'h7F);
    step(4);
    chk("blink_f2d1_com", 32'(seg_com), 32'hFF);
    step(60);
    chk("blink_f4_com", 32'(seg_com), 32'h7F);
    chk("blink_f4_txt", 32'(seg_txt), 32'h0);

    // key held across entry, then released and pressed again
    enable = 1'b0; mode = 2'b00; key_data = 12'h020;
    step(5);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("held_hit%0d", i), 32'(key_hit), 32'h0);
    end
    chk("held_busy", 32'(busy), 32'h1);
    key_data = '0; step(4);
    key_data = 12'h020; step(2);
    chk("press_hit_early", 32'(key_hit), 32'h0);
    chk("press_busy_early", 32'(busy), 32'h1);
    step(1);
    chk("press_hit", 32'(key_hit), 32'h1);
    chk("press_busy", 32'(busy), 32'h0);
    chk("press_com", 32'(seg_com), 32'hFF);
    step(1);
    chk("press_hit_off", 32'(key_hit), 32'h0);
    step(4);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_com", 32'(seg_com), 32'hFF);

    // glyph write during digit 3 slot
    key_data = '0; enable = 1'b0; step(2);
    enable = 1'b1; step(2);
    step(12);
    chk("wr_pre_txt", 32'(seg_txt), 32'h3);
    msg_we = 1'b1; msg_addr = 4'd3; msg_data = 7'h55;
    step(1);
    msg_we = 1'b0;
    chk("wr_same_slot_a", 32'(seg_txt), 32'h3);
    step(2);
    chk("wr_same_slot_b", 32'(seg_txt), 32'h3);
    step(29);
    chk("wr_next_com", 32'(seg_com), 32'hEF);
    chk("wr_next_txt", 32'(seg_txt), 32'h55);

    // asynchronous reset mid-frame
    step(5);
    rst_n = 1'b0;
    #1;
    chk("arst_com", 32'(seg_com), 32'hFF);
    chk("arst_txt", 32'(seg_txt), 32'h7F);
    chk("arst_busy", 32'(busy), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rearm_busy", 32'(busy), 32'h1);
    step(1);
    chk("rearm_com0", 32'(seg_com), 32'h7F);
    chk("rearm_txt0", 32'(seg_txt), 32'h7F);
    step(12);
    chk("rearm_com3", 32'(seg_com), 32'hEF);
    chk("rearm_txt3", 32'(seg_txt), 32'h7F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
